// File: rtl/bullet_ctrl.sv
// Per-player bullet engine: spawns at the tank centre on a fire edge, steps once per frame tick,
// and terminates on an opponent hit, a wall/border or lifetime expiry. Optional macro BULLET_BOUNCE_EN.
module bullet_ctrl #(
   parameter int SCREEN_W   = 1280,
   parameter int SCREEN_H   = 800,
   parameter int BORDER     = 16,
   parameter int BLK        = 32,
   parameter int SPEED      = 4,
   parameter int LIFETIME   = 180,
   parameter int COOLDOWN   = 30
`ifdef BULLET_BOUNCE_EN
   ,
   parameter int MAX_BOUNCE = 3
`endif
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tick,
   input  logic         fire,
   input  logic [2:0]   rot,
   input  logic [10:0]  tank_x,
   input  logic [9:0]   tank_y,
   input  logic [10:0]  opp_x,
   input  logic [9:0]   opp_y,
   input  logic [999:0] map0,
   output logic [10:0]  bull_x,
   output logic [9:0]   bull_y,
   output logic         bull_active,
   output logic         hit
);

   localparam int CELLS_X = SCREEN_W / BLK;
   localparam int CELLS_Y = SCREEN_H / BLK;
   localparam int CELL_SH = $clog2(BLK);
   localparam int LIFE_W  = $clog2(LIFETIME + 1);
   localparam int CNT_W   = $clog2(COOLDOWN + 1);
   localparam logic signed [11:0] X_MIN = 12'(BORDER + 4);
   localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - 1 - BORDER - 4);
   localparam logic signed [11:0] Y_MIN = 12'(BORDER + 4);
   localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - 1 - BORDER - 4);
   localparam logic signed [11:0] STEP  = 12'(SPEED);
   localparam logic [10:0] PARK_X = 11'd2000;
   localparam logic [9:0]  PARK_Y = 10'd1000;

   typedef enum logic [1:0] {IDLE, FLIGHT, CHECK, COOL} state_t;

   state_t             state;
   logic               fire_q;
   logic signed [1:0]  dx, dy;
   logic signed [11:0] nx, ny;
   logic [LIFE_W-1:0]  life;
   logic [CNT_W-1:0]   cnt;
`ifdef BULLET_BOUNCE_EN
   localparam int BNC_W = $clog2(MAX_BOUNCE + 1);
   logic [BNC_W-1:0]   bounce;
   logic               blk_x, blk_y;
`endif

   logic signed [11:0] cur_x, cur_y;
   logic [11:0]        ox, oy;
   logic               hit_c, blk_xy, life_end;

   assign cur_x = $signed({1'b0, bull_x});
   assign cur_y = $signed({2'b00, bull_y});
   assign ox    = {1'b0, opp_x};
   assign oy    = {2'b00, opp_y};

   function automatic logic signed [11:0] step(input logic signed [1:0] d);
      if (d == 2'sb01)
         step = STEP;
      else if (d == 2'sb11)
         step = -STEP;
      else
         step = '0;
   endfunction

   // Negative coordinates fall below the border limits in the signed compare, so they block too.
   function automatic logic blocked(input logic signed [11:0] x, input logic signed [11:0] y);
      logic        edge_b;
      logic [11:0] cx, cy, idx;
      edge_b  = (x < X_MIN) || (x > X_MAX) || (y < Y_MIN) || (y > Y_MAX);
      cx      = $unsigned(x) >> CELL_SH;
      cy      = $unsigned(y) >> CELL_SH;
      idx     = cy * 12'(CELLS_X) + cx;
      blocked = edge_b || ((idx < 12'(CELLS_X * CELLS_Y)) ? map0[idx[9:0]] : 1'b1);
   endfunction

   always_comb begin
      hit_c = !nx[11] && !ny[11] &&
              ($unsigned(nx) >= ox) && ($unsigned(nx) < ox + 12'(BLK)) &&
              ($unsigned(ny) >= oy) && ($unsigned(ny) < oy + 12'(BLK));
      blk_xy   = blocked(nx, ny);
      life_end = (life == LIFE_W'(LIFETIME));
`ifdef BULLET_BOUNCE_EN
      blk_x = blocked(nx, cur_y);
      blk_y = blocked(cur_x, ny);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         fire_q      <= 1'b0;
         dx          <= '0;
         dy          <= '0;
         nx          <= '0;
         ny          <= '0;
         life        <= '0;
         cnt         <= '0;
         bull_x      <= PARK_X;
         bull_y      <= PARK_Y;
         bull_active <= 1'b0;
         hit         <= 1'b0;
`ifdef BULLET_BOUNCE_EN
         bounce      <= '0;
`endif
      end else begin
         fire_q <= fire;
         hit    <= 1'b0;
         case (state)
            IDLE: begin
               if (fire && !fire_q) begin
                  bull_x      <= tank_x + 11'(BLK / 2);
                  bull_y      <= tank_y + 10'(BLK / 2);
                  life        <= '0;
                  bull_active <= 1'b1;
                  state       <= FLIGHT;
`ifdef BULLET_BOUNCE_EN
                  bounce      <= '0;
`endif
                  case (rot)
                     3'd0:    begin dx <= 2'sb00; dy <= 2'sb11; end
                     3'd1:    begin dx <= 2'sb01; dy <= 2'sb00; end
                     3'd2:    begin dx <= 2'sb00; dy <= 2'sb01; end
                     3'd3:    begin dx <= 2'sb11; dy <= 2'sb00; end
                     3'd4:    begin dx <= 2'sb01; dy <= 2'sb11; end
                     3'd5:    begin dx <= 2'sb01; dy <= 2'sb01; end
                     3'd6:    begin dx <= 2'sb11; dy <= 2'sb01; end
                     default: begin dx <= 2'sb11; dy <= 2'sb11; end
                  endcase
               end
            end
            FLIGHT: begin
               if (tick) begin
                  nx    <= cur_x + step(dx);
                  ny    <= cur_y + step(dy);
                  life  <= life + 1'b1;
                  state <= CHECK;
               end
            end
            CHECK: begin
               if (hit_c) begin
                  hit         <= 1'b1;
                  bull_x      <= PARK_X;
                  bull_y      <= PARK_Y;
                  bull_active <= 1'b0;
                  state       <= COOL;
`ifdef BULLET_BOUNCE_EN
               end else if (blk_x || blk_y || blk_xy) begin
                  if (bounce == BNC_W'(MAX_BOUNCE) || life_end) begin
                     bull_x      <= PARK_X;
                     bull_y      <= PARK_Y;
                     bull_active <= 1'b0;
                     state       <= COOL;
                  end else begin
                     // Position is held; only the direction flips on the blocking axis (both on a pure corner).
                     if (blk_x || blk_y) begin
                        if (blk_x) dx <= -dx;
                        if (blk_y) dy <= -dy;
                     end else begin
                        dx <= -dx;
                        dy <= -dy;
                     end
                     bounce <= bounce + 1'b1;
                     state  <= FLIGHT;
                  end
`else
               end else if (blk_xy) begin
                  bull_x      <= PARK_X;
                  bull_y      <= PARK_Y;
                  bull_active <= 1'b0;
                  state       <= COOL;
`endif
               end else if (life_end) begin
                  bull_x      <= PARK_X;
                  bull_y      <= PARK_Y;
                  bull_active <= 1'b0;
                  state       <= COOL;
               end else begin
                  bull_x <= nx[10:0];
                  bull_y <= ny[9:0];
                  state  <= FLIGHT;
               end
            end
            default: begin
               if (cnt == CNT_W'(COOLDOWN)) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else if (tick) begin
                  cnt <= cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bullet_ctrl.sv
// Directed bench for bullet_ctrl: expected outputs are queued as stimulus is applied and
// popped when the DUT output is due.
module tb_bullet_ctrl;

   logic         clk = 1'b0;
   logic         rst, tick, fire;
   logic [2:0]   rot;
   logic [10:0]  tank_x, opp_x;
   logic [9:0]   tank_y, opp_y;
   logic [999:0] map0;
   logic [10:0]  bull_x;
   logic [9:0]   bull_y;
   logic         bull_active, hit;

   bullet_ctrl #(
      .SCREEN_W(1280), .SCREEN_H(800), .BORDER(16), .BLK(32),
      .SPEED(4), .LIFETIME(180), .COOLDOWN(30)
   ) dut (
      .clk(clk), .rst(rst), .tick(tick), .fire(fire), .rot(rot),
      .tank_x(tank_x), .tank_y(tank_y), .opp_x(opp_x), .opp_y(opp_y),
      .map0(map0), .bull_x(bull_x), .bull_y(bull_y),
      .bull_active(bull_active), .hit(hit)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [10:0] x;
      logic [9:0]  y;
      logic        a;
      logic        h;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   hit_cnt  = 0;
   int   shot_cnt = 0;
   logic act_q    = 1'b0;
   int   base;

   always @(posedge clk) begin
      act_q <= bull_active;
      if (hit === 1'b1) hit_cnt <= hit_cnt + 1;
      if (bull_active === 1'b1 && act_q !== 1'b1) shot_cnt <= shot_cnt + 1;
   end

   task automatic push(input string tag, input int x, input int y, input bit a, input bit h);
      exp_t e;
      e.tag = tag;
      e.x   = 11'(x);
      e.y   = 10'(y);
      e.a   = a;
      e.h   = h;
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      n_assert++;
      assert (sb.size() != 0) else begin
         n_fail++;
         $error("FAIL scoreboard_empty got 0 entries exp 1");
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         n_assert++;
         assert (bull_x === e.x) else begin
            n_fail++;
            $error("FAIL %s bull_x got %0d exp %0d", e.tag, bull_x, e.x);
         end
         n_assert++;
         assert (bull_y === e.y) else begin
            n_fail++;
            $error("FAIL %s bull_y got %0d exp %0d", e.tag, bull_y, e.y);
         end
         n_assert++;
         assert (bull_active === e.a) else begin
            n_fail++;
            $error("FAIL %s bull_active got %b exp %b", e.tag, bull_active, e.a);
         end
         n_assert++;
         assert (hit === e.h) else begin
            n_fail++;
            $error("FAIL %s hit got %b exp %b", e.tag, hit, e.h);
         end
         $display("txn %s: bull=(%0d,%0d) active=%b hit=%b", e.tag, bull_x, bull_y, bull_active, hit);
      end
   endtask

   task automatic chk(input string tag, input int got, input int exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s got %0d exp %0d", tag, got, exp);
      end
      $display("txn %s: got %0d", tag, got);
   endtask

   // Tick edge moves FLIGHT->CHECK; the following edge updates the position.
   task automatic step_tick();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
   endtask

   task automatic press();
      fire = 1'b1;
      @(negedge clk);
      fire = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; tick = 1'b0; fire = 1'b0; rot = 3'd1;
      tank_x = 11'd100; tank_y = 10'd100; opp_x = 11'd1000; opp_y = 10'd600;
      map0 = '0;
      do_reset();
      push("reset", 2000, 1000, 0, 0);
      check_out();

      // spawn and straight-line motion to the right
      push("spawn", 116, 116, 1, 0);
      press();
      check_out();
      for (int k = 1; k <= 3; k++) begin
         push($sformatf("move%0d", k), 116 + 4 * k, 116, 1, 0);
         step_tick();
         check_out();
      end
      // one cycle after a tick the position must not have moved yet
      push("lat_hold", 128, 116, 1, 0);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      check_out();
      push("lat_upd", 132, 116, 1, 0);
      @(negedge clk);
      check_out();

      // reset mid-flight
      base = hit_cnt;
      do_reset();
      push("rst_mid", 2000, 1000, 0, 0);
      check_out();
      chk("rst_no_hit", hit_cnt - base, 0);
      push("rst_idle_fire", 116, 116, 1, 0);
      press();
      check_out();
      do_reset();

      // opponent hit on the sixth tick
      opp_x = 11'd140; opp_y = 10'd100;
      base = hit_cnt;
      push("hit_spawn", 116, 116, 1, 0);
      press();
      check_out();
      for (int k = 1; k <= 5; k++) begin
         push($sformatf("hit_move%0d", k), 116 + 4 * k, 116, 1, 0);
         step_tick();
         check_out();
      end
      push("hit_pulse", 2000, 1000, 0, 1);
      step_tick();
      check_out();
      push("hit_end", 2000, 1000, 0, 0);
      @(negedge clk);
      check_out();
      chk("hit_count", hit_cnt - base, 1);
      push("cool_fire_drop", 2000, 1000, 0, 0);
      press();
      @(negedge clk);
      check_out();
      do_reset();
      opp_x = 11'd1000; opp_y = 10'd600;

      // wall cell (5,1) at nx=160
      map0[45] = 1'b1;
      tank_x = 11'd100; tank_y = 10'd32; rot = 3'd1;
      push("wall_spawn", 116, 48, 1, 0);
      press();
      check_out();
      for (int k = 1; k <= 10; k++) begin
         push($sformatf("wall_move%0d", k), 116 + 4 * k, 48, 1, 0);
         step_tick();
         check_out();
      end
`ifdef BULLET_BOUNCE_EN
      push("wall_bounce", 156, 48, 1, 0);
      step_tick();
      check_out();
      push("wall_back", 152, 48, 1, 0);
      step_tick();
      check_out();
`else
      push("wall_park", 2000, 1000, 0, 0);
      step_tick();
      check_out();
`endif
      do_reset();
      map0 = '0;

      // fire held through flight, border termination and cooldown
      tank_x = 11'd1200; tank_y = 10'd300; rot = 3'd1;
      base = shot_cnt;
      fire = 1'b1;
      for (int i = 0; i < 500; i++) begin
         tick = (i % 5 == 0);
         @(negedge clk);
      end
      tick = 1'b0;
      chk("hold_shots", shot_cnt - base, 1);
      push("hold_parked", 2000, 1000, 0, 0);
      check_out();
      fire = 1'b0;
      @(negedge clk);
      push("hold_refire", 1216, 316, 1, 0);
      press();
      check_out();
      do_reset();

      // lifetime expiry then cooldown gating
      tank_x = 11'd300; tank_y = 10'd740; rot = 3'd0;
      push("life_spawn", 316, 756, 1, 0);
      press();
      check_out();
      repeat (178) step_tick();
      push("life179", 316, 756 - 4 * 179, 1, 0);
      step_tick();
      check_out();
      push("life180", 2000, 1000, 0, 0);
      step_tick();
      check_out();
      repeat (29) step_tick();
      push("cool29_reject", 2000, 1000, 0, 0);
      press();
      @(negedge clk);
      check_out();
      step_tick();
      push("cool30_accept", 316, 756, 1, 0);
      press();
      check_out();
      chk("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
